// File: rtl/func_rom_sequencer_pkg.sv
// Shared constants for the ROM timer / sequencer / FuncMUX slice.
// State codes and default widths live here so all three blocks agree.
package func_seq_pkg;

  localparam int DEF_FUNC_W = 4;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_STEPS  = 14;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef logic [1:0] state_t;

  typedef struct packed {
    logic v;
    logic last;
  } s1_t;

  function automatic logic is_busy(
    input state_t s
  );
    return s != IDLE;
  endfunction

endpackage

// File: rtl/func_rom_sequencer_if.sv
// Window/ROM/control-word bundle between timer, ROM, sequencer, FuncMUX.
// slave = the sequencer, master = its environment.
interface func_rom_sequencer_if #(
  parameter int FUNC_W = func_seq_pkg::DEF_FUNC_W,
  parameter int STEP_W = func_seq_pkg::DEF_STEP_W,
  parameter int DATA_W = func_seq_pkg::DEF_DATA_W
);

  logic                     ROMsel;
  logic [FUNC_W-1:0]        func_sel;
  logic                     rom_rd;
  logic [FUNC_W+STEP_W-1:0] rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [DATA_W-1:0]        ctrl_word;
  logic                     ctrl_valid;
  logic                     busy;
  logic                     done;
  logic                     abort;
  logic                     overrun;

  modport master (
    output ROMsel,
    output func_sel,
    output rom_data,
    input  rom_rd,
    input  rom_addr,
    input  ctrl_word,
    input  ctrl_valid,
    input  busy,
    input  done,
    input  abort,
    input  overrun
  );

  modport slave (
    input  ROMsel,
    input  func_sel,
    input  rom_data,
    output rom_rd,
    output rom_addr,
    output ctrl_word,
    output ctrl_valid,
    output busy,
    output done,
    output abort,
    output overrun
  );

endinterface

// File: rtl/func_rom_sequencer_rom_read_pipe.sv
// Two-stage ROM read pipeline: read tag stage, then registered control word.
// flush drops every in-flight read in the same cycle.
module rom_read_pipe
  import func_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              rd,
  input  logic              last,
  input  logic              flush,
  input  logic [DATA_W-1:0] rom_data,
  output logic              v1,
  output logic [DATA_W-1:0] ctrl_word,
  output logic              ctrl_valid,
  output logic              done
);

  s1_t s1;

  assign v1 = s1.v;

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      s1         <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
    end else if (flush) begin
      s1         <= '0;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      s1.v       <= rd;
      s1.last    <= rd & last;
      ctrl_valid <= s1.v;
      done       <= s1.v & s1.last;
      if (s1.v) ctrl_word <= rom_data;
    end
  end

endmodule

// File: rtl/func_rom_sequencer.sv
// Steps microcode ROM words {func, step} for each ROMsel window and streams
// them to the FuncMUX; flags done, early window loss and ignored retriggers.
module func_rom_sequencer
  import func_seq_pkg::*;
#(
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int STEPS  = DEF_STEPS,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic                Clk,
  input logic                Clear,
  func_rom_sequencer_if.slave bus
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] step;
  logic [FUNC_W-1:0] func_q;
  logic              ROMsel_q;
  logic              rise;
  logic              start;
  logic              last;
  logic              abort;
  logic              rd;
  logic              v1;

  assign rise  = bus.ROMsel & ~ROMsel_q;
  assign start = (state == IDLE) & rise;
  assign last  = (step == LAST);
  // Losing the window before the final read cancels the whole sequence.
  assign abort = (state == RUN) & ~last & ~bus.ROMsel;
  assign rd    = (state == RUN) & ~abort;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (rise) state_nx = RUN;
      end
      (state == RUN): begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DRAIN;
      end
      (state == DRAIN): begin
        if (!v1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state    <= IDLE;
      step     <= '0;
      func_q   <= '0;
      ROMsel_q <= 1'b0;
    end else begin
      ROMsel_q <= bus.ROMsel;
      state    <= state_nx;
      if (start) begin
        func_q <= bus.func_sel;
        step   <= '0;
      end else if (rd && !last) begin
        step <= step + STEP_W'(1);
      end
    end
  end

  assign bus.rom_rd   = rd;
  assign bus.rom_addr = {func_q, step};
  assign bus.busy     = is_busy(state);
  assign bus.abort    = abort;
  assign bus.overrun  = rise & is_busy(state);

  rom_read_pipe #(
    .DATA_W(DATA_W)
  ) u_pipe (
    .Clk       (Clk),
    .Clear     (Clear),
    .rd        (rd),
    .last      (last),
    .flush     (abort),
    .rom_data  (bus.rom_data),
    .v1        (v1),
    .ctrl_word (bus.ctrl_word),
    .ctrl_valid(bus.ctrl_valid),
    .done      (bus.done)
  );

endmodule

// File: tb/tb_func_rom_sequencer.sv
// Bench for func_rom_sequencer: directed windows plus random ROMsel bursts,
// checked every cycle against a cycles-since-rise reference model.
module tb_func_rom_sequencer;

  localparam int FW = 4;
  localparam int SW = 4;
  localparam int ST = 14;
  localparam int DW = 16;

  logic Clk = 1'b0;
  logic Clear;

  always #5 Clk = ~Clk;

  func_rom_sequencer_if #(
    .FUNC_W(FW), .STEP_W(SW), .DATA_W(DW)
  ) bus ();

  func_rom_sequencer #(
    .FUNC_W(FW), .STEP_W(SW), .STEPS(ST), .DATA_W(DW)
  ) dut (
    .Clk  (Clk),
    .Clear(Clear),
    .bus  (bus)
  );

  // ROM model: data = address zero-extended, one cycle after the read.
  always @(posedge Clk or posedge Clear) begin
    if (Clear) bus.rom_data <= '0;
    else if (bus.rom_rd) bus.rom_data <= DW'(bus.rom_addr);
  end

  int checks = 0;
  int failures = 0;

  bit          m_act;
  int          m_k;
  logic [3:0]  m_f;
  logic        m_prev;
  logic [15:0] m_word;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act  = 0;
    m_k    = 0;
    m_f    = '0;
    m_prev = 1'b0;
    m_word = '0;
  endtask

  // One clock cycle: drive inputs after the edge, check before the next.
  task automatic cyc(input logic r, input logic [3:0] fs);
    logic       rise;
    logic       e_busy, e_rd, e_val, e_done, e_ab, e_ov;
    logic [7:0] e_addr;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    bus.ROMsel = r;
    bus.func_sel = fs;
    @(negedge Clk);
    e_busy = 0; e_rd = 0; e_val = 0;
    e_done = 0; e_ab = 0; e_ov = 0;
    e_addr = '0;
    rise = r & ~m_prev;
    if (m_act) begin
      m_k++;
      if (m_k > ST + 2) m_act = 0;
    end
    if (m_act) begin
      e_busy = 1;
      e_ov = rise;
      if (m_k >= 3) begin
        e_val = 1;
        m_word = {8'h00, m_f, 4'(m_k - 3)};
      end
      if (m_k == ST + 2) e_done = 1;
      if (m_k <= ST - 1 && !r) begin
        e_ab = 1;
        m_act = 0;
      end else if (m_k <= ST) begin
        e_rd = 1;
        e_addr = {m_f, 4'(m_k - 1)};
      end
    end else if (rise) begin
      m_act = 1;
      m_k = 0;
      m_f = fs;
    end
    m_prev = r;
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("rom_rd", 32'(bus.rom_rd), 32'(e_rd));
    if (e_rd) chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
    chk("ctrl_valid", 32'(bus.ctrl_valid), 32'(e_val));
    chk("ctrl_word", 32'(bus.ctrl_word), 32'(m_word));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("abort", 32'(bus.abort), 32'(e_ab));
    chk("overrun", 32'(bus.overrun), 32'(e_ov));
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"}, 32'(bus.busy), 32'd0);
    chk({p, "_rd"}, 32'(bus.rom_rd), 32'd0);
    chk({p, "_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({p, "_valid"}, 32'(bus.ctrl_valid), 32'd0);
    chk({p, "_word"}, 32'(bus.ctrl_word), 32'd0);
    chk({p, "_done"}, 32'(bus.done), 32'd0);
    chk({p, "_abort"}, 32'(bus.abort), 32'd0);
    chk({p, "_ovr"}, 32'(bus.overrun), 32'd0);
  endtask

  // Async clear mid-cycle; it is released one cycle later by cyc().
  task automatic do_clear();
    #1;
    Clear = 1'b1;
    #1;
    chk_zero("clr");
    model_reset();
  endtask

  initial begin
    Clear = 1'b0;
    bus.ROMsel = 1'b0;
    bus.func_sel = '0;
    model_reset();
    #1;
    Clear = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk_zero("rst");

    // Normal sequence, func 3
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h3);

    // Back-to-back: rise on the first idle cycle after done
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h6);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h6);
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h7);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h7);

    // Abort after 5 high cycles
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'ha);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'ha);

    // Overrun on the cycle after the last read
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h2);
    cyc(1'b0, 4'h2);
    cyc(1'b1, 4'h2);
    cyc(1'b1, 4'h2);
    cyc(1'b1, 4'h2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h2);

    // Overrun on the DRAIN->IDLE cycle
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h4);
    cyc(1'b0, 4'h4);
    cyc(1'b0, 4'h4);
    cyc(1'b1, 4'h4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h4);

    // func_sel changes mid-sequence are ignored
    for (int i = 0; i < 14; i++) cyc(1'b1, (i < 7) ? 4'h3 : 4'h9);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h9);

    // Clear at step 8, ROMsel still high on release
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'hc);
    do_clear();
    for (int i = 0; i < 14; i++) cyc(1'b1, 4'h5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h5);

    // Random windows, occasional clear
    for (int b = 0; b < 250; b++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 17);
      lo = $urandom_range(1, 4);
      for (int i = 0; i < hi; i++) cyc(1'b1, 4'($urandom));
      if ($urandom_range(0, 19) == 0) do_clear();
      for (int i = 0; i < lo; i++) cyc(1'b0, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
